// File: rtl/sdf_bf_stage.sv
// ---------------------------------------------------------------------------
// sdf_bf_stage
// One radix-2 single-path-delay-feedback butterfly stage of the 32-point FFT
// pipeline. A DEPTH-entry delay line holds the first half of each frame. The
// second half is combined with it as a butterfly: the sums go straight out and
// the differences go back into the delay line. During the next frame's first
// half those differences leave through the twiddle multiplier. The stage
// addresses the external twiddle ROM from its sample counter and expects the
// twiddle pair back combinationally in the same cycle.
//
// Build option:
//   SDF_SAT_EN  - when defined, the add/sub results and the shifted multiply
//                 results saturate to the DW-bit signed range. When undefined,
//                 they wrap as two's complement. Latency is the same in both.
// ---------------------------------------------------------------------------
module sdf_bf_stage #(
  parameter int DEPTH     = 8,   // delay-line length; frame length 2*DEPTH, power of 2
  parameter int ADDR_BASE = 16,  // ROM address of twiddle index 0 (16 or 32)
  parameter int DW        = 22,  // signed sample width, real and imaginary
  parameter int FRAC      = 6    // twiddle fractional bits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  output logic [5:0]           rom_addr,
  input  logic signed [DW-1:0] tw_r,
  input  logic signed [DW-1:0] tw_i,
  output logic                 out_valid,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);

  // Index width into the delay line. The counter is one bit wider, and its
  // top bit distinguishes the two halves of the frame.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic signed [DW-1:0]  sample_t;  // stored and emitted sample
  typedef logic signed [DW:0]    ext_t;     // add/sub headroom
  typedef logic signed [2*DW:0]  wide_t;    // full complex-product width

  // Limits of the DW-bit signed range, held at product width for comparison.
  localparam wide_t SAT_HI = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam wide_t SAT_LO = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  // Narrows a wide intermediate result to DW bits, either wrapping or saturating.
  function automatic sample_t fit(input wide_t v);
`ifdef SDF_SAT_EN
    if (v > SAT_HI)      return sample_t'(SAT_HI);
    else if (v < SAT_LO) return sample_t'(SAT_LO);
    else                 return sample_t'(v);
`else
    return sample_t'(v);
`endif
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CW-1:0] cnt;       // position of the next accepted sample in its frame
  logic          primed;    // set once the first butterfly sample has been seen
  logic [AW-1:0] idx;       // delay-line slot paired with the current sample
  logic          bf_phase;  // second half of the frame: butterfly

  sample_t mem_r [DEPTH];
  sample_t mem_i [DEPTH];

  assign idx      = cnt[AW-1:0];
  assign bf_phase = cnt[AW];

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  sample_t head_r, head_i;    // delay-line output for this slot
  wide_t   prod_r, prod_i;    // full-width complex product
  wide_t   shft_r, shft_i;    // product scaled back by FRAC
  ext_t    sum_r,  sum_i;     // head + din at DW+1 bits
  ext_t    dif_r,  dif_i;     // head - din at DW+1 bits
  sample_t res_r,  res_i;     // value registered into dout this cycle
  sample_t push_r, push_i;    // value written back into the delay line

  assign head_r = mem_r[idx];
  assign head_i = mem_i[idx];

  // ROM address: walk the twiddle table during the first half of the frame and
  // park on index 0 (twiddle 1) during the butterfly half or when idle.
  always_comb begin
    rom_addr = 6'(ADDR_BASE);
    if (in_valid && !bf_phase)
      rom_addr = 6'(ADDR_BASE) + 6'(cnt);
  end

  // Complex multiply, butterfly add/sub, and selection of result and write-back.
  always_comb begin
    // NOTE: every signal written here gets a value first; a path that leaves
    // one unassigned would infer a latch.
    res_r  = '0;
    res_i  = '0;
    push_r = din_r;
    push_i = din_i;

    prod_r = wide_t'(head_r) * wide_t'(tw_r) - wide_t'(head_i) * wide_t'(tw_i);
    prod_i = wide_t'(head_r) * wide_t'(tw_i) + wide_t'(head_i) * wide_t'(tw_r);
    shft_r = prod_r >>> FRAC;
    shft_i = prod_i >>> FRAC;

    sum_r  = ext_t'(head_r) + ext_t'(din_r);
    sum_i  = ext_t'(head_i) + ext_t'(din_i);
    dif_r  = ext_t'(head_r) - ext_t'(din_r);
    dif_i  = ext_t'(head_i) - ext_t'(din_i);

    if (bf_phase) begin
      res_r  = fit(wide_t'(sum_r));
      res_i  = fit(wide_t'(sum_i));
      push_r = fit(wide_t'(dif_r));
      push_i = fit(wide_t'(dif_i));
    end else begin
      res_r  = fit(shft_r);
      res_i  = fit(shft_i);
    end
  end

  // Delay-line write: the slot just read is refilled with din (first half) or
  // with the butterfly difference (second half).
  // NOTE: the delay line has no reset; its contents before the first full
  // frame never reach a valid output because out_valid is gated by primed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_r[idx] <= push_r;
      mem_i[idx] <= push_i;
    end
  end

  // Control and output registers: advance on each accepted sample, otherwise hold.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        cnt       <= cnt + CW'(1);
        out_valid <= bf_phase | primed;
        dout_r    <= res_r;
        dout_i    <= res_i;
        if (bf_phase)
          primed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdf_bf_stage.sv
// ---------------------------------------------------------------------------
// tb_sdf_bf_stage
// Bench for sdf_bf_stage with the default parameters (DEPTH=8, ADDR_BASE=16,
// DW=22, FRAC=6). A twiddle ROM model answers rom_addr combinationally. The
// expected results come from a frame-level model: it stores the raw samples of
// each frame and computes sums, differences and twiddled differences from
// them directly.
// ---------------------------------------------------------------------------
module tb_sdf_bf_stage;

  localparam int  DW   = 22;
  localparam int  DEP  = 8;
  localparam int  FLEN = 2 * DEP;
  localparam int  BASE = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] din_r = '0;
  logic signed [DW-1:0] din_i = '0;
  logic [5:0]           rom_addr;
  logic signed [DW-1:0] tw_r;
  logic signed [DW-1:0] tw_i;
  logic                 out_valid;
  logic signed [DW-1:0] dout_r;
  logic signed [DW-1:0] dout_i;

  sdf_bf_stage #(.DEPTH(DEP), .ADDR_BASE(BASE), .DW(DW), .FRAC(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .din_r    (din_r),
    .din_i    (din_i),
    .rom_addr (rom_addr),
    .tw_r     (tw_r),
    .tw_i     (tw_i),
    .out_valid(out_valid),
    .dout_r   (dout_r),
    .dout_i   (dout_i)
  );

  always #5 clk = ~clk;

  // Twiddle table W16^k = exp(-j*2*pi*k/16) in Q6, k = 0..7.
  int twr_tab [8] = '{64, 59, 45, 24, 0, -24, -45, -59};
  int twi_tab [8] = '{0, -24, -45, -59, -64, -59, -45, -24};

  // External ROM: combinational answer for the stage's address range.
  always_comb begin
    int k;
    tw_r = '0;
    tw_i = '0;
    k    = int'(rom_addr) - BASE;
    if (k >= 0 && k < 8) begin
      tw_r = DW'(twr_tab[k]);
      tw_i = DW'(twi_tab[k]);
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level reference model
  // ---------------------------------------------------------------------------
  longint fr_r [FLEN];   // raw samples of the current frame
  longint fr_i [FLEN];
  longint pd_r [DEP];    // differences of the previous frame
  longint pd_i [DEP];
  int     m_n;           // accepted samples since reset
  bit     m_primed;
  bit     m_known;       // whether the registered output value is defined
  longint m_last_r, m_last_i;

  function automatic longint fitm(input longint v);
    longint lo, hi, m;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
`ifdef SDF_SAT_EN
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    m = v & ((longint'(1) <<< DW) - 1);
    if (m > hi) m = m - (longint'(1) <<< DW);
    return m;
`endif
  endfunction

  task automatic model_reset();
    m_n      = 0;
    m_primed = 1'b0;
    m_known  = 1'b1;
    m_last_r = 0;
    m_last_i = 0;
  endtask

  function automatic int model_addr(input bit v);
    int pos;
    pos = m_n % FLEN;
    return (v && pos < DEP) ? BASE + pos : BASE;
  endfunction

  // Applies one accepted sample to the model and returns the expected output.
  task automatic model_step(input longint xr, input longint xi,
                            output bit ev, output longint er, output longint ei);
    int pos;
    longint pr, pi;
    pos = m_n % FLEN;
    if (pos < DEP) begin
      pr = pd_r[pos] * twr_tab[pos] - pd_i[pos] * twi_tab[pos];
      pi = pd_r[pos] * twi_tab[pos] + pd_i[pos] * twr_tab[pos];
      er = fitm(pr >>> 6);
      ei = fitm(pi >>> 6);
      ev = m_primed;
      m_known = m_primed;
    end else begin
      er = fitm(fr_r[pos-DEP] + xr);
      ei = fitm(fr_i[pos-DEP] + xi);
      pd_r[pos-DEP] = fitm(fr_r[pos-DEP] - xr);
      pd_i[pos-DEP] = fitm(fr_i[pos-DEP] - xi);
      ev = 1'b1;
      m_primed = 1'b1;
      m_known  = 1'b1;
    end
    fr_r[pos] = xr;
    fr_i[pos] = xi;
    m_last_r  = er;
    m_last_i  = ei;
    m_n++;
  endtask

  // One clock cycle, checked against the model. Entered away from the edge.
  task automatic cyc(input bit v, input longint xr, input longint xi);
    bit     ev;
    longint er, ei;
    int     ea;
    ea       = model_addr(v);
    in_valid = v;
    din_r    = DW'(xr);
    din_i    = DW'(xi);
    #2;
    check("rom_addr", longint'(rom_addr), longint'(ea));
    ev = 1'b0;
    er = m_last_r;
    ei = m_last_i;
    if (v) model_step(xr, xi, ev, er, ei);
    @(posedge clk);
    #1;
    check("out_valid", longint'(out_valid), longint'(ev));
    if (ev || (!v && m_known)) begin
      check(v ? "dout_r" : "dout_r_hold", longint'(dout_r), er);
      check(v ? "dout_i" : "dout_i_hold", longint'(dout_i), ei);
    end
  endtask

  // Asynchronous reset, with the outputs checked before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_dout_r", longint'(dout_r), 0);
    check("rst_dout_i", longint'(dout_i), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Table-driven twiddle-path vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    int xr;
    int xi;
    int addr;
    bit ev;
    int er;
    int ei;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int r, i;
    bit vld;

    // Twiddle-path table: 8 zeros, 8 x -64, 8 zeros.
    for (int k = 0; k < 8; k++) tbl[k]    = '{1'b1, 0,   0, BASE + k, 1'b0, 0, 0};
    for (int k = 0; k < 8; k++) tbl[8+k]  = '{1'b1, -64, 0, BASE,     1'b1, -64, 0};
    for (int k = 0; k < 8; k++) tbl[16+k] = '{1'b1, 0,   0, BASE + k, 1'b1, twr_tab[k], twi_tab[k]};

    model_reset();
    #12;
    do_reset();

    for (int k = 0; k < 24; k++) begin
      in_valid = tbl[k].v;
      din_r    = DW'(tbl[k].xr);
      din_i    = DW'(tbl[k].xi);
      #2;
      check("tbl_rom_addr", longint'(rom_addr), longint'(tbl[k].addr));
      @(posedge clk);
      #1;
      check("tbl_out_valid", longint'(out_valid), longint'(tbl[k].ev));
      if (tbl[k].ev) begin
        check("tbl_dout_r", longint'(dout_r), longint'(tbl[k].er));
        check("tbl_dout_i", longint'(dout_i), longint'(tbl[k].ei));
      end
    end

    // Impulse: 64 then zeros for one frame, then a zero frame.
    do_reset();
    for (int k = 0; k < 2 * FLEN; k++) cyc(1'b1, (k == 0) ? 64 : 0, 0);

    // Constant input (64,64) for two frames.
    do_reset();
    for (int k = 0; k < 2 * FLEN; k++) cyc(1'b1, 64, 64);

    // Gaps: impulse again with an idle cycle after every sample.
    do_reset();
    for (int k = 0; k < 2 * FLEN; k++) begin
      cyc(1'b1, (k == 0) ? 64 : 0, 0);
      cyc(1'b0, 0, 0);
    end

    // Reset in mid-frame after sample 11, then eight quiet samples and a BF one.
    do_reset();
    for (int k = 0; k < 12; k++) cyc(1'b1, 100, -50);
    do_reset();
    for (int k = 0; k < DEP + 1; k++) cyc(1'b1, 7 * k, -3 * k);

    // Overflow: samples 0 and 8 at the positive limit.
    do_reset();
    for (int k = 0; k < 2 * FLEN; k++)
      cyc(1'b1, (k == 0 || k == DEP) ? 2097151 : 0, 0);
    do_reset();
    for (int k = 0; k < 2 * FLEN; k++)
      cyc(1'b1, (k == 0 || k == DEP) ? -2097152 : 0, (k == 0) ? 2097151 : -2097152);

    // Random traffic with random gaps and occasional resets.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k % 500 == 499) do_reset();
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, 255)) - 128;
        i = int'($urandom_range(0, 255)) - 128;
      end else begin
        r = int'($urandom_range(0, 4194303)) - 2097152;
        i = int'($urandom_range(0, 4194303)) - 2097152;
      end
      cyc(vld, longint'(r), longint'(i));
    end

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
